// File: rtl/axi_lite_rw_master.sv
// -----------------------------------------------------------------------------
// axi_lite_rw_master
//
// Single-outstanding AXI4-Lite master that serves both loads and stores from
// one request port. A request is accepted while ready=1. Writes drive AW and W
// together and let each channel complete on its own. The B response is then
// collected. Reads drive AR and then collect R. Completion is reported with a
// one-cycle done pulse. resp_err is qualified by done.
//
// Optional build macro: AXI_TIMEOUT_EN
//   When defined, a transaction that has not completed TIMEOUT_CYCLES cycles
//   after accept is abandoned. It is then reported as done with resp_err=1.
//   When undefined, the block waits indefinitely.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start_read, start_write  request strobes (write wins if both are high)
//   req_addr                 request address, sampled at accept
//   write_data, write_strb   write payload and byte enables, sampled at accept
//   ready                    idle, a request can be accepted this cycle
//   done                     one-cycle completion pulse
//   read_valid               one-cycle pulse, read_data updated this cycle
//   read_data                last read result, held until the next read
//   resp_err                 with done: slave error response or timeout
//   m_axil_*                 AXI4-Lite master interface (AW, W, B, AR, R)
// -----------------------------------------------------------------------------
module axi_lite_rw_master #(
    parameter  int DATA_WIDTH     = 32,
    parameter  int ADDR_WIDTH     = 5,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_read,
    input  logic                  start_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [STRB_WIDTH-1:0] write_strb,
    output logic                  ready,
    output logic                  done,
    output logic                  read_valid,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  resp_err,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    input  logic [1:0]            m_axil_bresp,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp
);

    // Elaboration-time parameter sanity checks.
    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_t;

    state_t                r_state,      w_state_next;
    logic                  r_awvalid,    w_awvalid_next;
    logic                  r_wvalid,     w_wvalid_next;
    logic                  r_bready,     w_bready_next;
    logic                  r_arvalid,    w_arvalid_next;
    logic                  r_rready,     w_rready_next;
    logic                  r_done,       w_done_next;
    logic                  r_read_valid, w_read_valid_next;
    logic                  r_resp_err,   w_resp_err_next;
    logic [DATA_WIDTH-1:0] r_read_data,  w_read_data_next;
    logic [ADDR_WIDTH-1:0] r_awaddr,     w_awaddr_next;
    logic [ADDR_WIDTH-1:0] r_araddr,     w_araddr_next;
    logic [DATA_WIDTH-1:0] r_wdata,      w_wdata_next;
    logic [STRB_WIDTH-1:0] r_wstrb,      w_wstrb_next;

    // A write channel is finished once its valid has dropped, or when it
    // handshakes this cycle.
    logic w_aw_ok, w_w_ok;
    assign w_aw_ok = !r_awvalid || m_axil_awready;
    assign w_w_ok  = !r_wvalid  || m_axil_wready;

`ifdef AXI_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] r_timer;
    logic               w_timeout;

    // The counter is held at zero in IDLE, so it starts from zero at accept.
    // It saturates at TIMEOUT_CYCLES. Expiry is acted on in the following cycle.
    assign w_timeout = (r_state != IDLE) && (r_timer == TIMER_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE) begin
            r_timer <= '0;
        end else if (!w_timeout) begin
            r_timer <= r_timer + 1'b1;
        end
    end
`endif

    always_comb begin
        // NOTE: every next-state value gets a default first. No path through
        // the case statement can leave one unassigned, so no latch is inferred.
        w_state_next      = r_state;
        w_awvalid_next    = r_awvalid;
        w_wvalid_next     = r_wvalid;
        w_bready_next     = r_bready;
        w_arvalid_next    = r_arvalid;
        w_rready_next     = r_rready;
        w_done_next       = 1'b0;
        w_read_valid_next = 1'b0;
        w_resp_err_next   = 1'b0;
        w_read_data_next  = r_read_data;
        w_awaddr_next     = r_awaddr;
        w_araddr_next     = r_araddr;
        w_wdata_next      = r_wdata;
        w_wstrb_next      = r_wstrb;

        unique case (r_state)
            IDLE: begin
                if (start_write) begin
                    w_awaddr_next  = req_addr;
                    w_wdata_next   = write_data;
                    w_wstrb_next   = write_strb;
                    w_awvalid_next = 1'b1;
                    w_wvalid_next  = 1'b1;
                    w_state_next   = WR_REQ;
                end else if (start_read) begin
                    w_araddr_next  = req_addr;
                    w_arvalid_next = 1'b1;
                    w_state_next   = RD_REQ;
                end
            end
            WR_REQ: begin
                if (r_awvalid && m_axil_awready) w_awvalid_next = 1'b0;
                if (r_wvalid  && m_axil_wready)  w_wvalid_next  = 1'b0;
                if (w_aw_ok && w_w_ok) begin
                    w_bready_next = 1'b1;
                    w_state_next  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil_bvalid && r_bready) begin
                    w_bready_next   = 1'b0;
                    w_done_next     = 1'b1;
                    w_resp_err_next = (m_axil_bresp != 2'b00);
                    w_state_next    = IDLE;
                end
            end
            RD_REQ: begin
                if (r_arvalid && m_axil_arready) begin
                    w_arvalid_next = 1'b0;
                    w_rready_next  = 1'b1;
                    w_state_next   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axil_rvalid && r_rready) begin
                    w_read_data_next  = m_axil_rdata;
                    w_read_valid_next = 1'b1;
                    w_done_next       = 1'b1;
                    w_resp_err_next   = (m_axil_rresp != 2'b00);
                    w_rready_next     = 1'b0;
                    w_state_next      = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

`ifdef AXI_TIMEOUT_EN
        // A completion in the expiry cycle has already moved next state to
        // IDLE, so the normal completion takes priority over the timeout.
        if (w_timeout && w_state_next != IDLE) begin
            w_awvalid_next    = 1'b0;
            w_wvalid_next     = 1'b0;
            w_bready_next     = 1'b0;
            w_arvalid_next    = 1'b0;
            w_rready_next     = 1'b0;
            w_done_next       = 1'b1;
            w_resp_err_next   = 1'b1;
            w_read_valid_next = 1'b0;
            w_state_next      = IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every
        // register samples values from before this edge.
        if (rst) begin
            r_state      <= IDLE;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_done       <= 1'b0;
            r_read_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_read_data  <= '0;
            r_awaddr     <= '0;
            r_araddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_awvalid    <= w_awvalid_next;
            r_wvalid     <= w_wvalid_next;
            r_bready     <= w_bready_next;
            r_arvalid    <= w_arvalid_next;
            r_rready     <= w_rready_next;
            r_done       <= w_done_next;
            r_read_valid <= w_read_valid_next;
            r_resp_err   <= w_resp_err_next;
            r_read_data  <= w_read_data_next;
            r_awaddr     <= w_awaddr_next;
            r_araddr     <= w_araddr_next;
            r_wdata      <= w_wdata_next;
            r_wstrb      <= w_wstrb_next;
        end
    end

    assign ready          = (r_state == IDLE);
    assign done           = r_done;
    assign read_valid     = r_read_valid;
    assign read_data      = r_read_data;
    assign resp_err       = r_resp_err;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_awaddr  = r_awaddr;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_bready  = r_bready;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_araddr  = r_araddr;
    assign m_axil_rready  = r_rready;

endmodule
